// File: rtl/ahb_slave_response_mux_if.sv
// Bus bundle between the AHB response mux and its four slaves, address decoder and master.
// The slave modport is the mux's view; the master modport drives the mux's inputs.
interface ahb_slave_response_mux_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [1:0]            Multiplexor_SEL;
  logic                  SEL_VALID;
  logic [1:0]            HTRANS;
  logic [DATA_WIDTH-1:0] HRDATA_1;
  logic [DATA_WIDTH-1:0] HRDATA_2;
  logic [DATA_WIDTH-1:0] HRDATA_3;
  logic [DATA_WIDTH-1:0] HRDATA_4;
  logic                  HREADYOUT_1;
  logic                  HREADYOUT_2;
  logic                  HREADYOUT_3;
  logic                  HREADYOUT_4;
  logic                  HRESP_1;
  logic                  HRESP_2;
  logic                  HRESP_3;
  logic                  HRESP_4;
  logic [DATA_WIDTH-1:0] HRDATA;
  logic                  HREADY;
  logic                  HRESP;

  modport slave (
    input  Multiplexor_SEL, SEL_VALID, HTRANS,
    input  HRDATA_1, HRDATA_2, HRDATA_3, HRDATA_4,
    input  HREADYOUT_1, HREADYOUT_2, HREADYOUT_3, HREADYOUT_4,
    input  HRESP_1, HRESP_2, HRESP_3, HRESP_4,
    output HRDATA, HREADY, HRESP
  );

  modport master (
    output Multiplexor_SEL, SEL_VALID, HTRANS,
    output HRDATA_1, HRDATA_2, HRDATA_3, HRDATA_4,
    output HREADYOUT_1, HREADYOUT_2, HREADYOUT_3, HREADYOUT_4,
    output HRESP_1, HRESP_2, HRESP_3, HRESP_4,
    input  HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/ahb_slave_response_mux.sv
// AHB return-path mux: registers the decoder select for the data phase and routes one of four
// slaves back to the master; unmapped transfers get a two-cycle ERROR from the built-in default slave.
module ahb_slave_response_mux #(
  parameter int unsigned SLAVE_NUM  = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic                   HCLK,
  input logic                   HRESET,
  ahb_slave_response_mux_if.slave bus
);

  localparam int unsigned SEL_W = $clog2(SLAVE_NUM);

  typedef enum logic [1:0] {
    DS_IDLE,
    DS_ERR1,
    DS_ERR2
  } ds_state_t;

  logic [SEL_W-1:0]      dp_sel;
  logic                  dp_act;
  logic                  dp_def;
  ds_state_t             ds_state;
  logic                  ds_ready;
  logic                  ds_resp;

  logic [DATA_WIDTH-1:0] sl_data;
  logic                  sl_ready;
  logic                  sl_resp;
  logic [DATA_WIDTH-1:0] hrdata;
  logic                  hready;
  logic                  hresp;
  logic                  unmapped_req;
  logic                  unused_ok;

  assign unused_ok    = bus.HTRANS[0];
  assign unmapped_req = hready & bus.HTRANS[1] & ~bus.SEL_VALID;

  // Address phase is captured only on edges that complete the current data phase.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dp_sel <= '0;
      dp_act <= 1'b0;
      dp_def <= 1'b0;
    end else if (hready) begin
      dp_sel <= bus.Multiplexor_SEL;
      dp_act <= bus.HTRANS[1];
      dp_def <= bus.HTRANS[1] & ~bus.SEL_VALID;
    end
  end

  // Default slave: ERR1 always advances, so the ERROR response is never cut short.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      ds_state <= DS_IDLE;
      ds_ready <= 1'b1;
      ds_resp  <= 1'b0;
    end else begin
      case (ds_state)
        DS_IDLE: begin
          if (unmapped_req) begin
            ds_state <= DS_ERR1;
            ds_ready <= 1'b0;
            ds_resp  <= 1'b1;
          end
        end
        DS_ERR1: begin
          ds_state <= DS_ERR2;
          ds_ready <= 1'b1;
          ds_resp  <= 1'b1;
        end
        DS_ERR2: begin
          if (unmapped_req) begin
            ds_state <= DS_ERR1;
            ds_ready <= 1'b0;
            ds_resp  <= 1'b1;
          end else begin
            ds_state <= DS_IDLE;
            ds_ready <= 1'b1;
            ds_resp  <= 1'b0;
          end
        end
        default: begin
          ds_state <= DS_IDLE;
          ds_ready <= 1'b1;
          ds_resp  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    sl_data  = bus.HRDATA_1;
    sl_ready = bus.HREADYOUT_1;
    sl_resp  = bus.HRESP_1;
    case (dp_sel)
      2'd1: begin
        sl_data  = bus.HRDATA_2;
        sl_ready = bus.HREADYOUT_2;
        sl_resp  = bus.HRESP_2;
      end
      2'd2: begin
        sl_data  = bus.HRDATA_3;
        sl_ready = bus.HREADYOUT_3;
        sl_resp  = bus.HRESP_3;
      end
      2'd3: begin
        sl_data  = bus.HRDATA_4;
        sl_ready = bus.HREADYOUT_4;
        sl_resp  = bus.HRESP_4;
      end
      default: begin
        sl_data  = bus.HRDATA_1;
        sl_ready = bus.HREADYOUT_1;
        sl_resp  = bus.HRESP_1;
      end
    endcase
  end

  always_comb begin
    hrdata = '0;
    hready = 1'b1;
    hresp  = 1'b0;
    if (dp_act) begin
      if (dp_def) begin
        hready = ds_ready;
        hresp  = ds_resp;
      end else begin
        hrdata = sl_data;
        hready = sl_ready;
        hresp  = sl_resp;
      end
    end
  end

  assign bus.HRDATA = hrdata;
  assign bus.HREADY = hready;
  assign bus.HRESP  = hresp;

endmodule

// File: tb/tb_ahb_slave_response_mux.sv
// Directed bench for ahb_slave_response_mux: each step drives inputs just after a rising edge
// and checks {HREADY, HRESP, HRDATA} before the next edge.
module tb_ahb_slave_response_mux;

  logic HCLK;
  logic HRESET;
  int unsigned compared;
  int unsigned mismatched;

  ahb_slave_response_mux_if #(.DATA_WIDTH(32)) bus ();

  ahb_slave_response_mux #(
    .SLAVE_NUM (4),
    .DATA_WIDTH(32)
  ) dut (
    .HCLK  (HCLK),
    .HRESET(HRESET),
    .bus   (bus)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic rdy, input logic rsp, input logic [31:0] dat);
    logic [33:0] obs;
    logic [33:0] exp;
    #1;
    obs = {bus.HREADY, bus.HRESP, bus.HRDATA};
    exp = {rdy, rsp, dat};
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed rdy/rsp/data=%b/%b/%h expected=%b/%b/%h",
             tag, obs[33], obs[32], obs[31:0], exp[33], exp[32], exp[31:0]);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;

    // Test 1: reset with slaves driving X
    HRESET              = 1'b1;
    bus.Multiplexor_SEL = 2'd0;
    bus.SEL_VALID       = 1'b1;
    bus.HTRANS          = 2'b00;
    bus.HRDATA_1 = 'x; bus.HRDATA_2 = 'x; bus.HRDATA_3 = 'x; bus.HRDATA_4 = 'x;
    bus.HREADYOUT_1 = 1'bx; bus.HREADYOUT_2 = 1'bx; bus.HREADYOUT_3 = 1'bx; bus.HREADYOUT_4 = 1'bx;
    bus.HRESP_1 = 1'bx; bus.HRESP_2 = 1'bx; bus.HRESP_3 = 1'bx; bus.HRESP_4 = 1'bx;
    tick();
    chk("reset_hold", 1'b1, 1'b0, 32'h0);
    tick();
    HRESET = 1'b0;
    chk("reset_release", 1'b1, 1'b0, 32'h0);

    bus.HRDATA_1 = 32'hAAAA_0001; bus.HRDATA_2 = 32'hBBBB_0002;
    bus.HRDATA_3 = 32'hCAFE_0003; bus.HRDATA_4 = 32'hDDDD_0004;
    bus.HREADYOUT_1 = 1'b1; bus.HREADYOUT_2 = 1'b1; bus.HREADYOUT_3 = 1'b1; bus.HREADYOUT_4 = 1'b1;
    bus.HRESP_1 = 1'b0; bus.HRESP_2 = 1'b0; bus.HRESP_3 = 1'b0; bus.HRESP_4 = 1'b0;

    // Test 2: NONSEQ to slave 3 with two wait states
    tick();
    bus.Multiplexor_SEL = 2'd2;
    bus.HTRANS          = 2'b10;
    bus.HREADYOUT_3     = 1'b0;
    chk("s3_addr", 1'b1, 1'b0, 32'h0);
    tick();
    bus.HTRANS          = 2'b00;
    bus.Multiplexor_SEL = 2'd0;
    chk("s3_wait1", 1'b0, 1'b0, 32'hCAFE_0003);
    tick();
    chk("s3_wait2", 1'b0, 1'b0, 32'hCAFE_0003);
    tick();
    bus.HREADYOUT_3 = 1'b1;
    chk("s3_done", 1'b1, 1'b0, 32'hCAFE_0003);
    tick();
    chk("s3_after", 1'b1, 1'b0, 32'h0);

    // Test 3: back-to-back slave 1 then slave 4, zero wait
    bus.Multiplexor_SEL = 2'd0;
    bus.HTRANS          = 2'b10;
    tick();
    bus.Multiplexor_SEL = 2'd3;
    bus.HTRANS          = 2'b11;
    chk("b2b_s1", 1'b1, 1'b0, 32'hAAAA_0001);
    tick();
    bus.HTRANS = 2'b00;
    chk("b2b_s4", 1'b1, 1'b0, 32'hDDDD_0004);
    tick();
    chk("b2b_idle", 1'b1, 1'b0, 32'h0);

    // Slave ERROR passes through unchanged
    bus.Multiplexor_SEL = 2'd1;
    bus.HTRANS          = 2'b10;
    bus.HRESP_2         = 1'b1;
    tick();
    bus.HTRANS = 2'b00;
    chk("s2_err_pass", 1'b1, 1'b1, 32'hBBBB_0002);
    bus.HRESP_2 = 1'b0;

    // Test 4: unmapped NONSEQ; master goes IDLE during ERR1
    tick();
    bus.SEL_VALID = 1'b0;
    bus.HTRANS    = 2'b10;
    tick();
    bus.HTRANS    = 2'b00;
    bus.SEL_VALID = 1'b1;
    chk("def_err1", 1'b0, 1'b1, 32'h0);
    tick();
    chk("def_err2", 1'b1, 1'b1, 32'h0);
    tick();
    chk("def_okay", 1'b1, 1'b0, 32'h0);

    // Two unmapped transfers back-to-back
    bus.SEL_VALID = 1'b0;
    bus.HTRANS    = 2'b10;
    tick();
    chk("b2b_def_a1", 1'b0, 1'b1, 32'h0);
    tick();
    bus.HTRANS = 2'b11;
    chk("b2b_def_a2", 1'b1, 1'b1, 32'h0);
    tick();
    bus.HTRANS    = 2'b00;
    bus.SEL_VALID = 1'b1;
    chk("b2b_def_b1", 1'b0, 1'b1, 32'h0);
    tick();
    chk("b2b_def_b2", 1'b1, 1'b1, 32'h0);
    tick();
    chk("b2b_def_done", 1'b1, 1'b0, 32'h0);

    // Test 5: IDLE and BUSY with SEL_VALID=0 raise no ERROR
    bus.SEL_VALID = 1'b0;
    bus.HTRANS    = 2'b00;
    tick();
    bus.HTRANS = 2'b01;
    chk("unmapped_idle", 1'b1, 1'b0, 32'h0);
    tick();
    bus.HTRANS = 2'b00;
    chk("unmapped_busy", 1'b1, 1'b0, 32'h0);

    // Test 6a: reset during ERR1
    bus.HTRANS = 2'b10;
    tick();
    bus.HTRANS    = 2'b00;
    bus.SEL_VALID = 1'b1;
    chk("rst_err1_pre", 1'b0, 1'b1, 32'h0);
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
    chk("rst_err1_post", 1'b1, 1'b0, 32'h0);
    tick();
    chk("rst_err1_idle", 1'b1, 1'b0, 32'h0);

    // Test 6b: reset during a slave-2 wait state; stalled HREADYOUT_2 then ignored
    bus.Multiplexor_SEL = 2'd1;
    bus.HTRANS          = 2'b10;
    bus.HREADYOUT_2     = 1'b0;
    tick();
    bus.HTRANS = 2'b00;
    chk("rst_s2_wait", 1'b0, 1'b0, 32'hBBBB_0002);
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
    chk("rst_s2_post", 1'b1, 1'b0, 32'h0);
    tick();
    chk("rst_s2_idle", 1'b1, 1'b0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
